net_packet_serializer: RTL and testbench

Host-side source for the core network. It accepts a stream of 32-bit words from the host/testbench over a valid/ready handshake and assembles header+data word pairs into `net_packet_s`. Completed packets are buffered in a small FIFO. It emits at most one packet per cycle onto the network bus that the core and the packet logger observe. Idle cycles drive `net_op = NULL`.

---
 rtl/net_packet_serializer_pkg.sv | 61 ++++++
 rtl/net_packet_serializer_fifo.sv | 72 +++++++
 rtl/net_packet_serializer.sv | 165 ++++++++++++++++
 tb/tb_net_packet_serializer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/net_packet_serializer_pkg.sv
// Shared network definitions: operation codes, packet bus format, host header layout.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package net_packet_serializer_pkg;

    // Network operation codes carried on the packet bus. NULL marks an idle cycle.
    typedef enum logic [2:0] {
        NULL  = 3'd0,
        INSTR = 3'd1,
        REG   = 3'd2,
        PC    = 3'd3,
        BAR   = 3'd4
    } net_op_e;

    localparam int NET_ID_W   = 10;
    localparam int NET_ADDR_W = 16;
    localparam int NET_DATA_W = 32;

    typedef struct packed {
        net_op_e                 net_op;
        logic [NET_ID_W-1:0]     net_id;
        logic [NET_ADDR_W-1:0]   net_addr;
        logic [NET_DATA_W-1:0]   net_data;
    } net_packet_s;

    // Host header word field positions.
    localparam int HDR_OP_LSB   = 29;
    localparam int HDR_OP_W     = 3;
    localparam int HDR_RSVD_LSB = 26;
    localparam int HDR_RSVD_W   = 3;
    localparam int HDR_ID_LSB   = 16;
    localparam int HDR_ID_W     = 10;
    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_ADDR_W   = 16;

    // Field order matches the LSB constants above, MSB first.
    typedef struct packed {
        logic [HDR_OP_W-1:0]   op;
        logic [HDR_RSVD_W-1:0] rsvd;
        logic [HDR_ID_W-1:0]   id;
        logic [HDR_ADDR_W-1:0] addr;
    } net_hdr_s;

    // Serializer FSM states.
    typedef enum logic {
        S_HDR  = 1'b0,
        S_DATA = 1'b1
    } ser_state_e;

    // True when the raw op field names a defined net_op_e value.
    function automatic logic net_op_defined(input logic [HDR_OP_W-1:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            NULL, INSTR, REG, PC, BAR: ok = 1'b1;
            default:                   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/net_packet_serializer_fifo.sv
// Generic synchronous FIFO holding assembled packets; same-cycle push and pop allowed.
// Latency: a pushed element is visible at the head on the cycle after the push edge.
// Backpressure: o_full from the registered count; pushing while full is the caller's bug.
//
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset (pointers and count cleared)
//   i_push, i_data   write strobe and element
//   i_pop            read strobe; o_data is the current head (fall-through)
//   o_full, o_empty  status decoded from the registered count
//   o_count          registered occupancy, 0..els_p
module net_packet_fifo #(
    parameter int width_p = 8,
    parameter int els_p   = 4,
    localparam int AW     = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int CNT_W  = $clog2(els_p) + 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_push,
    input  logic [width_p-1:0] i_data,
    input  logic               i_pop,
    output logic [width_p-1:0] o_data,
    output logic               o_full,
    output logic               o_empty,
    output logic [CNT_W-1:0]   o_count
);

    logic [width_p-1:0] r_mem [els_p];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    // Guard both strobes so a misbehaving caller cannot corrupt the pointers.
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    assign o_full  = (r_count == CNT_W'(els_p));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/net_packet_serializer.sv
// Assembles host header+data word pairs into packets, buffers them, emits one per cycle.
// Latency: packet appears on net_packet_o 2 cycles after its data-word handshake (empty FIFO, net ready).
// Backpressure: host_ready_o drops only in S_DATA while the FIFO is full; net_ready_i low stalls output losslessly.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   host_data_i/valid_i/ready_o      host word stream (header, then data)
//   net_ready_i                      network accepts a packet this cycle
//   net_packet_o                     registered packet, all-zero (NULL) when idle
//   pkt_count_o                      packets emitted, wrapping
//   drop_count_o                     malformed headers dropped, saturating
//   busy_o                           mid-packet or packets still buffered
module net_packet_serializer
    import net_packet_serializer_pkg::*;
#(
    parameter int fifo_els_p = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] host_data_i,
    input  logic        host_valid_i,
    output logic        host_ready_o,
    input  logic        net_ready_i,
    output net_packet_s net_packet_o,
    output logic [31:0] pkt_count_o,
    output logic [15:0] drop_count_o,
    output logic        busy_o
);

    localparam int CNT_W = $clog2(fifo_els_p) + 1;

    ser_state_e            r_state;
    ser_state_e            w_state_nxt;
    net_op_e               r_op;
    logic [NET_ID_W-1:0]   r_id;
    logic [NET_ADDR_W-1:0] r_addr;
    net_packet_s           r_packet;
    logic [31:0]           r_pkt_count;
    logic [15:0]           r_drop_count;

    net_hdr_s              w_hdr;
    logic                  w_hdr_bad;
    logic                  w_hdr_take;
    logic                  w_push;
    logic                  w_pop;
    net_packet_s           w_push_pkt;
    logic [$bits(net_packet_s)-1:0] w_head_raw;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [CNT_W-1:0]      w_fifo_count;

    assign w_hdr = host_data_i;

    // Next state and host handshake. Ready never looks at host_valid_i, and in
    // S_DATA it looks only at the registered FIFO count, so a same-cycle pop
    // does not reopen it.
    always_comb begin
        w_state_nxt  = r_state;
        host_ready_o = 1'b1;
        w_hdr_bad    = 1'b0;
        w_hdr_take   = 1'b0;
        w_push       = 1'b0;
        case (r_state)
            S_HDR: begin
                host_ready_o = 1'b1;
                if (host_valid_i) begin
                    if ((w_hdr.rsvd != '0) || !net_op_defined(w_hdr.op)) begin
                        w_hdr_bad = 1'b1;
                    end else if (w_hdr.op != NULL) begin
                        w_hdr_take  = 1'b1;
                        w_state_nxt = S_DATA;
                    end
                    // op == NULL with clean reserved bits: keepalive, discarded.
                end
            end
            S_DATA: begin
                host_ready_o = !w_fifo_full;
                if (host_valid_i && !w_fifo_full) begin
                    w_push      = 1'b1;
                    w_state_nxt = S_HDR;
                end
            end
            default: begin
                w_state_nxt = S_HDR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_HDR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latched header fields; cleared on reset so a half-received packet is forgotten.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op   <= NULL;
            r_id   <= '0;
            r_addr <= '0;
        end else if (w_hdr_take) begin
            r_op   <= net_op_e'(w_hdr.op);
            r_id   <= NET_ID_W'(w_hdr.id);
            r_addr <= NET_ADDR_W'(w_hdr.addr);
        end
    end

    always_comb begin
        w_push_pkt          = '0;
        w_push_pkt.net_op   = r_op;
        w_push_pkt.net_id   = r_id;
        w_push_pkt.net_addr = r_addr;
        w_push_pkt.net_data = NET_DATA_W'(host_data_i);
    end

    assign w_pop = !w_fifo_empty && net_ready_i;

    net_packet_fifo #(
        .width_p ($bits(net_packet_s)),
        .els_p   (fifo_els_p)
    ) u_fifo (
        .i_clk   (clk),
        .i_reset (reset),
        .i_push  (w_push),
        .i_data  (w_push_pkt),
        .i_pop   (w_pop),
        .o_data  (w_head_raw),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // Output register: the head for exactly one cycle per pop, otherwise NULL.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_packet <= '0;
        end else if (w_pop) begin
            r_packet <= net_packet_s'(w_head_raw);
        end else begin
            r_packet <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pkt_count  <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_pop) begin
                r_pkt_count <= r_pkt_count + 32'd1;
            end
            if (w_hdr_bad && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    assign net_packet_o = r_packet;
    assign pkt_count_o  = r_pkt_count;
    assign drop_count_o = r_drop_count;
    assign busy_o       = (r_state == S_DATA) || (w_fifo_count != '0);

endmodule

// File: tb/tb_net_packet_serializer.sv
// Directed bench for net_packet_serializer: reset, latency, backpressure, drops, keepalives, mid-packet reset, wrap.
// Latency: n/a (testbench).
// Backpressure: drives net_ready_i low to fill the FIFO and observe the host stall.
module tb_net_packet_serializer;
    import net_packet_serializer_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] host_data_i;
    logic        host_valid_i;
    logic        host_ready_o;
    logic        net_ready_i;
    net_packet_s net_packet_o;
    logic [31:0] pkt_count_o;
    logic [15:0] drop_count_o;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    net_packet_s mon_q[$];
    int          mon_cyc[$];

    net_packet_serializer #(.fifo_els_p(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .host_data_i  (host_data_i),
        .host_valid_i (host_valid_i),
        .host_ready_o (host_ready_o),
        .net_ready_i  (net_ready_i),
        .net_packet_o (net_packet_o),
        .pkt_count_o  (pkt_count_o),
        .drop_count_o (drop_count_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every non-idle packet cycle, sampled away from the active edge.
    always @(negedge clk) begin
        if (!reset && (net_packet_o.net_op != NULL)) begin
            mon_q.push_back(net_packet_o);
            mon_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic net_packet_s mk_pkt(input net_op_e op, input logic [9:0] id,
                                           input logic [15:0] addr, input logic [31:0] data);
        net_packet_s p;
        p.net_op   = op;
        p.net_id   = id;
        p.net_addr = addr;
        p.net_data = data;
        return p;
    endfunction

    // Complete a handshake on the word already driven; bounded wait on ready.
    task automatic wait_hs(output int hs_cyc);
        bit done;
        done   = 1'b0;
        hs_cyc = -1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (host_ready_o) begin
                hs_cyc = cyc;
                done   = 1'b1;
            end
        end
        if (!done) chk("hs_timeout", 64'(done), 64'd1);
        @(posedge clk);
        #1;
        host_valid_i = 1'b0;
    endtask

    task automatic send(input logic [31:0] w);
        int c;
        host_data_i  = w;
        host_valid_i = 1'b1;
        wait_hs(c);
    endtask

    task automatic send_c(input logic [31:0] w, output int c);
        host_data_i  = w;
        host_valid_i = 1'b1;
        wait_hs(c);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_q.delete();
        mon_cyc.delete();
    endtask

    initial begin
        int hs;
        reset        = 1'b1;
        host_data_i  = '0;
        host_valid_i = 1'b0;
        net_ready_i  = 1'b1;
        idle(3);
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_ready", 64'(host_ready_o), 64'd1);
        chk("rst_pkt",   64'(net_packet_o), 64'd0);
        chk("rst_pcnt",  64'(pkt_count_o),  64'd0);
        chk("rst_drop",  64'(drop_count_o), 64'd0);
        chk("rst_busy",  64'(busy_o),       64'd0);
        @(posedge clk);
        #1;

        // Single INSTR packet, latency and one-cycle visibility
        clear_mon();
        send(32'h2005_0010);
        send_c(32'h1234_5678, hs);
        idle(8);
        chk("t1_npkts", 64'(mon_q.size()), 64'd1);
        if (mon_q.size() >= 1) begin
            chk("t1_pkt", 64'(mon_q[0]), 64'(mk_pkt(INSTR, 10'h005, 16'h0010, 32'h1234_5678)));
            chk("t1_lat", 64'(mon_cyc[0] - hs), 64'd2);
        end
        chk("t1_pcnt", 64'(pkt_count_o), 64'd1);
        chk("t1_busy", 64'(busy_o), 64'd0);

        // NULL keepalives between BAR packets
        clear_mon();
        send(32'h0000_1234);
        send(32'h80AA_0B0B);
        send(32'hB000_0001);
        send(32'h0000_1234);
        send(32'h03FF_FFFF);
        send(32'h8155_0C0C);
        send(32'hB000_0002);
        idle(8);
        chk("ka_npkts", 64'(mon_q.size()), 64'd2);
        if (mon_q.size() >= 2) begin
            chk("ka_pkt0", 64'(mon_q[0]), 64'(mk_pkt(BAR, 10'h0AA, 16'h0B0B, 32'hB000_0001)));
            chk("ka_pkt1", 64'(mon_q[1]), 64'(mk_pkt(BAR, 10'h155, 16'h0C0C, 32'hB000_0002)));
        end
        chk("ka_drop", 64'(drop_count_o), 64'd0);
        chk("ka_pcnt", 64'(pkt_count_o),  64'd3);

        // Backpressure: 5 REG packets into a 4-deep FIFO with the network stalled
        clear_mon();
        net_ready_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            send(32'h4000_0000 | (32'(i) << 16) | (32'h0100 + 32'(i)));
            send(32'hA000_0000 + 32'(i));
        end
        send(32'h4005_0105);
        host_data_i  = 32'hA000_0005;
        host_valid_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("bp_ready_low", 64'(host_ready_o), 64'd0);
        chk("bp_busy",      64'(busy_o),       64'd1);
        chk("bp_noemit",    64'(mon_q.size()), 64'd0);
        net_ready_i = 1'b1;
        wait_hs(hs);
        idle(15);
        chk("bp_npkts", 64'(mon_q.size()), 64'd5);
        for (int i = 0; i < 5 && i < mon_q.size(); i++) begin
            chk($sformatf("bp_pkt%0d", i), 64'(mon_q[i]),
                64'(mk_pkt(REG, 10'(i + 1), 16'(16'h0100 + 16'(i + 1)), 32'hA000_0000 + 32'(i + 1))));
        end
        chk("bp_pcnt", 64'(pkt_count_o), 64'd8);

        // Malformed headers dropped, valid PC packet passes
        clear_mon();
        send(32'h7401_0001);
        idle(1);
        chk("drop_rsvd", 64'(drop_count_o), 64'd1);
        send(32'hE000_0000);
        idle(1);
        chk("drop_op", 64'(drop_count_o), 64'd2);
        send(32'h63FF_FFFF);
        send(32'hDEAD_BEEF);
        idle(8);
        chk("drop_npkts", 64'(mon_q.size()), 64'd1);
        if (mon_q.size() >= 1) begin
            chk("drop_pkt", 64'(mon_q[0]), 64'(mk_pkt(PC, 10'h3FF, 16'hFFFF, 32'hDEAD_BEEF)));
        end
        chk("drop_pcnt", 64'(pkt_count_o), 64'd9);

        // Reset between header and data
        clear_mon();
        send(32'h2001_0002);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        @(negedge clk);
        chk("mr_pcnt",  64'(pkt_count_o),  64'd0);
        chk("mr_drop",  64'(drop_count_o), 64'd0);
        chk("mr_busy",  64'(busy_o),       64'd0);
        chk("mr_ready", 64'(host_ready_o), 64'd1);
        @(posedge clk);
        #1;
        // Reserved bits nonzero: dropped as a header, would be a packet if taken as data.
        send(32'h1234_5678);
        idle(8);
        chk("mr_npkts", 64'(mon_q.size()), 64'd0);
        chk("mr_hdr",   64'(drop_count_o), 64'd1);

        // Packet counter wrap
        clear_mon();
        @(negedge clk);
        dut.r_pkt_count = 32'hFFFF_FFFF;
        #1;
        chk("wrap_pre", 64'(pkt_count_o), 64'hFFFF_FFFF);
        @(posedge clk);
        #1;
        send(32'h2002_0003);
        send(32'h0000_00FF);
        idle(8);
        chk("wrap_npkts", 64'(mon_q.size()), 64'd1);
        chk("wrap_pcnt",  64'(pkt_count_o),  64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
